timer_cntr_ctrl: RTL and testbench
==================================

# timer_cntr_ctrl

Programmable interval-timer controller that sequences an external `cntr_up_clr_nb` counter instance. It latches a period, prescale and mode on `start` and drives the counter's `clr`/`ld`/`up`/`D` inputs. It watches the counter's `rco` to detect expiry, then produces a one-cycle `expired` pulse and a sticky `irq`. It sits between the MCU's memory-mapped timer registers and the counter datapath, and supports one-shot and drift-free auto-reload operation.

## Interface
- `N`, 8: counter width; must equal the `n` of the driven counter.
- `P`, 8: prescaler width.

- `clk` in 1: system clock; all state changes on rising edge.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: arm or re-arm the timer; level sampled each edge.
- `stop` in 1: abort the timer; level sampled each edge; priority over `start`.
- `mode` in 1: 0 = one-shot, 1 = auto-reload; latched on start acceptance.
- `period` in N: ticks per expiry; 0 means 2^N ticks; latched on start acceptance.
- `prescale` in P: one tick every `prescale`+1 clocks; latched on start acceptance.
- `irq_ack` in 1: clears `irq`.
- `cnt_rco` in 1: counter `rco` (count == all ones).
- `cnt_clr` out 1: to counter `clr`.
- `cnt_ld` out 1: to counter `ld`.
- `cnt_up` out 1: to counter `up`.
- `cnt_D` out N: to counter `D`.
- `busy` out 1: high in LOAD or RUN.
- `expired` out 1: registered; one-cycle pulse per expiry.
- `irq` out 1: registered, sticky expiry flag.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset value is IDLE.
- IDLE transitions:
  - `stop` → stay IDLE.
  - `start` → LOAD; latch `period`, `prescale`, `mode` into shadow registers.
- LOAD:
  - `cnt_ld`=1 and `cnt_D` = two's-complement negation of the latched period (2^N − period, mod 2^N).
  - Prescaler counter cleared to 0.
  - Next state RUN; `stop` → HALT instead.
- RUN:
  - Prescaler counts 0..prescale and wraps; `tick` = (pre_cnt == latched prescale).
  - `cnt_up` = `tick`, except in the expiry cycle (see below).
- Expiry = RUN & `tick` & `cnt_rco`, which falls on the period-th tick. In that cycle:
  - Auto-reload: `cnt_ld`=1, `cnt_up`=0, `cnt_D` = −period; stay RUN. Prescaler wraps normally, giving zero drift.
  - One-shot: `cnt_up`=0, so the counter holds all ones; next state IDLE.
  - Either mode: `expired` is high in the following cycle and `irq` is set.
- `stop` in RUN → HALT. `stop` overrides a same-cycle expiry: no `expired` pulse, `irq` unchanged, `cnt_up`/`cnt_ld` = 0.
- `start` (without `stop`) in RUN → LOAD. New values are latched, and a same-cycle expiry still pulses `expired` and sets `irq`.
- HALT: `cnt_clr`=1 for one cycle, then IDLE.
- Control outputs are combinational from state, `tick`, `cnt_rco` and `clr`:
  - `cnt_clr` = `clr` | (state == HALT).
  - `cnt_D` = −latched period at all times.
- `irq`: set by expiry, cleared by `irq_ack`. Set wins over a same-cycle `irq_ack`.
- Reset (any state, including mid-RUN):
  - Next cycle: IDLE, shadow registers, prescaler, `expired` and `irq` all 0.
  - While `clr`=1: `cnt_clr`=1, `cnt_ld`=`cnt_up`=0, `busy`=0.

## Timing
- `start` sampled high at the end of cycle c. LOAD is cycle c+1. RUN begins at c+2 with the counter holding −period.
- First tick in cycle c+2+prescale. Expiry tick in cycle c+1+period·(prescale+1), with period 0 counting as 2^N. `expired` and `irq` go high one cycle later.
- Auto-reload: `expired` pulses exactly period·(prescale+1) cycles apart.
- One-shot: `busy` falls in the same cycle `expired` rises.
- `stop` latency: HALT in the next cycle, IDLE one cycle after that.

## Test plan
- N=8, P=8, period=3, prescale=0, mode=0, `start` in cycle 0:
  - `cnt_ld`=1 with `cnt_D`=8'hFD in cycle 1.
  - `cnt_up`=1 in cycles 2–3; expiry cycle 4 with `cnt_up`=0.
  - `expired`=1 and `irq`=1 in cycle 5, `busy`=0 in cycle 5.
- period=4, prescale=2, mode=1, `start` in cycle 0:
  - `cnt_ld`=1 in cycles 1, 13, 25.
  - `expired` pulses in cycles 14, 26, 38; counter sequence FC→FD→FE→FF→FC.
- period=0, prescale=0, one-shot: `cnt_D`=8'h00; `expired` in cycle 258 after 256 ticks.
- Auto-reload run, `stop` asserted exactly on an expiry cycle:
  - No `expired` pulse, `irq` stays 0.
  - HALT next cycle with `cnt_clr`=1, then IDLE with `busy`=0.
- `irq_ack` held high across an expiry: `irq` rises anyway; `irq` clears the cycle after `irq_ack` is asserted alone.
- `clr` asserted mid-RUN: `cnt_clr`=1 during reset, then IDLE with all outputs 0. A restart in RUN with period=5 reloads `cnt_D`=8'hFB and expires 5 ticks later.

Source files
------------

// File: rtl/timer_cntr_ctrl_if.sv
// Bundles the MCU-side timer register signals and the counter-side
// control/status signals of timer_cntr_ctrl into one port.
// The slave modport is the controller's view of the bundle.
// The master modport is the environment's view (MCU plus counter).
interface timer_cntr_ctrl_if #(
    parameter int N = 8,
    parameter int P = 8
);
    // MCU side
    logic         start;
    logic         stop;
    logic         mode;
    logic [N-1:0] period;
    logic [P-1:0] prescale;
    logic         irq_ack;
    logic         busy;
    logic         expired;
    logic         irq;

    // Counter side
    logic         cnt_rco;
    logic         cnt_clr;
    logic         cnt_ld;
    logic         cnt_up;
    logic [N-1:0] cnt_D;

    modport slave (
        input  start, stop, mode, period, prescale, irq_ack, cnt_rco,
        output cnt_clr, cnt_ld, cnt_up, cnt_D, busy, expired, irq
    );

    modport master (
        output start, stop, mode, period, prescale, irq_ack, cnt_rco,
        input  cnt_clr, cnt_ld, cnt_up, cnt_D, busy, expired, irq
    );
endinterface

// File: rtl/timer_cntr_ctrl.sv
// Interval-timer controller that sequences an external up counter.
// The counter is loaded with -period and counts up once per prescaled tick.
// Its rco on a tick marks the period-th tick, i.e. expiry.
// Auto-reload reloads the counter in the expiry cycle itself.
// The prescaler keeps wrapping through that cycle, so successive expiries do not drift.
module timer_cntr_ctrl #(
    parameter int N = 8,
    parameter int P = 8
) (
    input  logic             clk,
    input  logic             clr,
    timer_cntr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_period;
    logic [P-1:0] r_prescale;
    logic         r_mode;
    logic [P-1:0] r_pre_cnt;
    logic         r_expired;
    logic         r_irq;

    logic w_tick;
    logic w_expiry;
    logic w_fire;
    logic w_accept;

    // Tick is the last clock of a prescale window.
    // Expiry is a tick on which the counter already reads all ones.
    assign w_tick   = (r_state == S_RUN) && (r_pre_cnt == r_prescale);
    assign w_expiry = w_tick && bus.cnt_rco;
    // A same-cycle stop cancels the expiry entirely (no pulse, no irq, no reload)
    assign w_fire   = w_expiry && !bus.stop;
    // New settings are accepted from IDLE or as a re-arm while running
    assign w_accept = bus.start && !bus.stop &&
                      ((r_state == S_IDLE) || (r_state == S_RUN));

    // Counter controls are combinational so the counter reacts in the same cycle
    assign bus.cnt_clr = clr || (r_state == S_HALT);
    assign bus.cnt_ld  = !clr && ((r_state == S_LOAD) || (w_fire && r_mode));
    assign bus.cnt_up  = !clr && w_tick && !bus.cnt_rco;
    assign bus.cnt_D   = -r_period;
    assign bus.busy    = !clr && ((r_state == S_LOAD) || (r_state == S_RUN));
    assign bus.expired = r_expired;
    assign bus.irq     = r_irq;

    // Control FSM with shadow registers, prescaler and registered status flags
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_period   <= '0;
            r_prescale <= '0;
            r_mode     <= 1'b0;
            r_pre_cnt  <= '0;
            r_expired  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_expired <= w_fire;

            // Setting wins over a simultaneous acknowledge
            if (w_fire) begin
                r_irq <= 1'b1;
            end else if (bus.irq_ack) begin
                r_irq <= 1'b0;
            end

            if (w_accept) begin
                r_period   <= bus.period;
                r_prescale <= bus.prescale;
                r_mode     <= bus.mode;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_pre_cnt <= '0;
                    r_state   <= bus.stop ? S_HALT : S_RUN;
                end
                S_RUN: begin
                    // The prescaler wraps even on an expiry tick, which keeps reloads drift-free
                    r_pre_cnt <= w_tick ? '0 : r_pre_cnt + P'(1);
                    if (bus.stop) begin
                        r_state <= S_HALT;
                    end else if (w_accept) begin
                        r_state <= S_LOAD;
                    end else if (w_expiry && !r_mode) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cntr_ctrl.sv
// Self-checking bench for timer_cntr_ctrl.
// It contains a behavioural model of the driven up counter (clr > ld > up, rco = all ones).
// Expected values come from closed-form timing arithmetic on period and prescale.
module tb_timer_cntr_ctrl;
    localparam int N = 8;
    localparam int P = 8;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    timer_cntr_ctrl_if #(.N(N), .P(P)) bus ();

    timer_cntr_ctrl #(.N(N), .P(P)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // External counter model
    logic [N-1:0] cnt;
    always_ff @(posedge clk) begin
        if (bus.cnt_clr)     cnt <= '0;
        else if (bus.cnt_ld) cnt <= bus.cnt_D;
        else if (bus.cnt_up) cnt <= cnt + 1'b1;
    end
    assign bus.cnt_rco = &cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ack;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_ack = 1'b1;
        next_cycle();
        bus.irq_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset;
        clr = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (bus.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL reset cnt_clr got %b exp 1", bus.cnt_clr); end
        n_checks++; if (bus.cnt_ld !== 1'b0) begin n_fail++; $display("FAIL reset cnt_ld got %b exp 0", bus.cnt_ld); end
        n_checks++; if (bus.cnt_up !== 1'b0) begin n_fail++; $display("FAIL reset cnt_up got %b exp 0", bus.cnt_up); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL reset expired got %b exp 0", bus.expired); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset irq got %b exp 0", bus.irq); end
        clr = 1'b0;
        next_cycle();
        #1;
        n_checks++; if (bus.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL reset_idle cnt_clr got %b exp 0", bus.cnt_clr); end
        n_checks++; if (bus.cnt_D !== 8'h00) begin n_fail++; $display("FAIL reset_idle cnt_D got %h exp 00", bus.cnt_D); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b exp 0", bus.busy); end
        $display("reset: done, checks so far %0d", n_checks);
    endtask

    // Starts a run in cycle 0 and checks every output in cycles 1..ncyc-1 against timing arithmetic.
    // Auto-reload runs are then stopped and the HALT/IDLE sequence is checked.
    task automatic run_check(input int p, input int s, input int m, input int ncyc, input string name);
        int pe, len, t, tc, ec;
        logic e_ld, e_up, e_busy, e_exp, e_irq;
        logic [7:0] e_cnt, e_d;
        pe  = (p == 0) ? 256 : p;
        len = pe * (s + 1);
        ec  = (256 - pe) % 256;
        e_d = 8'(ec);
        for (int k = 0; k < ncyc; k++) begin
            if (k == 0) begin
                bus.start    = 1'b1;
                bus.stop     = 1'b0;
                bus.period   = 8'(p);
                bus.prescale = 8'(s);
                bus.mode     = 1'(m);
            end else begin
                // Scramble inputs after acceptance: the controller must use its latched copies
                bus.start    = 1'b0;
                bus.period   = 8'($urandom);
                bus.prescale = 8'($urandom);
                bus.mode     = 1'($urandom);
            end
            #1;
            if (k >= 1) begin
                e_ld   = (k == 1) || (m != 0 && k >= 1 + len && (k - 1) % len == 0);
                e_up   = (k >= 2) && ((k - 2) % (s + 1) == s) &&
                         !(k >= 1 + len && (k - 1) % len == 0) && (m != 0 || k < 1 + len);
                e_busy = (m != 0) || (k <= 1 + len);
                e_exp  = (k >= 2 + len) && ((k - 2) % len == 0) && (m != 0 || k == 2 + len);
                e_irq  = (k >= 2 + len);
                n_checks++; if (bus.cnt_ld !== e_ld) begin n_fail++; $display("FAIL %s k=%0d cnt_ld got %b exp %b", name, k, bus.cnt_ld, e_ld); end
                n_checks++; if (bus.cnt_up !== e_up) begin n_fail++; $display("FAIL %s k=%0d cnt_up got %b exp %b", name, k, bus.cnt_up, e_up); end
                n_checks++; if (bus.busy !== e_busy) begin n_fail++; $display("FAIL %s k=%0d busy got %b exp %b", name, k, bus.busy, e_busy); end
                n_checks++; if (bus.expired !== e_exp) begin n_fail++; $display("FAIL %s k=%0d expired got %b exp %b", name, k, bus.expired, e_exp); end
                n_checks++; if (bus.irq !== e_irq) begin n_fail++; $display("FAIL %s k=%0d irq got %b exp %b", name, k, bus.irq, e_irq); end
                n_checks++; if (bus.cnt_D !== e_d) begin n_fail++; $display("FAIL %s k=%0d cnt_D got %h exp %h", name, k, bus.cnt_D, e_d); end
                n_checks++; if (bus.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL %s k=%0d cnt_clr got %b exp 0", name, k, bus.cnt_clr); end
                if (k >= 2) begin
                    t  = (k - 2) / (s + 1);
                    tc = (m != 0) ? (t % pe) : ((t < pe - 1) ? t : pe - 1);
                    e_cnt = 8'((256 - pe + tc) % 256);
                    n_checks++; if (cnt !== e_cnt) begin n_fail++; $display("FAIL %s k=%0d counter got %h exp %h", name, k, cnt, e_cnt); end
                end
            end
            next_cycle();
        end
        bus.start = 1'b0;
        if (m != 0) begin
            bus.stop = 1'b1;
            #1;
            next_cycle();
            bus.stop = 1'b0;
            #1;
            n_checks++; if (bus.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL %s halt cnt_clr got %b exp 1", name, bus.cnt_clr); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s halt busy got %b exp 0", name, bus.busy); end
            next_cycle();
            #1;
            n_checks++; if (bus.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL %s idle cnt_clr got %b exp 0", name, bus.cnt_clr); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s idle busy got %b exp 0", name, bus.busy); end
        end
        $display("%s: period=%0d prescale=%0d mode=%0d cycles=%0d, checks so far %0d", name, p, s, m, ncyc, n_checks);
    endtask

    task automatic test_oneshot_basic;
        idle_ack();
        run_check(3, 0, 0, 8, "oneshot_basic");
    endtask

    task automatic test_autoreload;
        idle_ack();
        run_check(4, 2, 1, 40, "autoreload");
    endtask

    task automatic test_period_zero;
        idle_ack();
        run_check(0, 0, 0, 262, "period_zero");
    endtask

    task automatic test_stop_on_expiry;
        idle_ack();
        bus.start = 1'b1; bus.period = 8'd2; bus.prescale = 8'd1; bus.mode = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        for (int k = 1; k < 5; k++) next_cycle();
        // Cycle 5 is the first expiry tick (period 2 * 2 clocks)
        bus.stop = 1'b1;
        #1;
        n_checks++; if (bus.cnt_rco !== 1'b1) begin n_fail++; $display("FAIL stop_exp rco got %b exp 1", bus.cnt_rco); end
        n_checks++; if (bus.cnt_ld !== 1'b0) begin n_fail++; $display("FAIL stop_exp cnt_ld got %b exp 0", bus.cnt_ld); end
        n_checks++; if (bus.cnt_up !== 1'b0) begin n_fail++; $display("FAIL stop_exp cnt_up got %b exp 0", bus.cnt_up); end
        next_cycle();
        bus.stop = 1'b0;
        #1;
        n_checks++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL stop_exp_halt expired got %b exp 0", bus.expired); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL stop_exp_halt irq got %b exp 0", bus.irq); end
        n_checks++; if (bus.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL stop_exp_halt cnt_clr got %b exp 1", bus.cnt_clr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_exp_halt busy got %b exp 0", bus.busy); end
        next_cycle();
        #1;
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL stop_exp_idle irq got %b exp 0", bus.irq); end
        n_checks++; if (bus.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL stop_exp_idle cnt_clr got %b exp 0", bus.cnt_clr); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_exp_idle busy got %b exp 0", bus.busy); end
        n_checks++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL stop_exp_idle counter got %h exp 00", cnt); end
        $display("stop_on_expiry: done, checks so far %0d", n_checks);
    endtask

    task automatic test_irq_ack;
        idle_ack();
        // period 2, prescale 0, one-shot: expiry in cycle 3, irq in cycle 4
        bus.start = 1'b1; bus.period = 8'd2; bus.prescale = 8'd0; bus.mode = 1'b0;
        bus.irq_ack = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (bus.cnt_rco !== 1'b1) begin n_fail++; $display("FAIL irq_ack rco got %b exp 1", bus.cnt_rco); end
        next_cycle();
        bus.irq_ack = 1'b0;
        #1;
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_ack_set irq got %b exp 1", bus.irq); end
        n_checks++; if (bus.expired !== 1'b1) begin n_fail++; $display("FAIL irq_ack_set expired got %b exp 1", bus.expired); end
        next_cycle();
        #1;
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_sticky irq got %b exp 1", bus.irq); end
        n_checks++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL irq_sticky expired got %b exp 0", bus.expired); end
        next_cycle();
        bus.irq_ack = 1'b1;
        #1;
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL irq_ack_cycle irq got %b exp 1", bus.irq); end
        next_cycle();
        bus.irq_ack = 1'b0;
        #1;
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared irq got %b exp 0", bus.irq); end
        $display("irq_ack: done, checks so far %0d", n_checks);
    endtask

    task automatic test_clr_mid_run;
        idle_ack();
        // period 2, prescale 0, auto-reload: expiries in cycles 3,5,...; pulses in 4,6,...
        bus.start = 1'b1; bus.period = 8'd2; bus.prescale = 8'd0; bus.mode = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        for (int k = 1; k < 5; k++) next_cycle();
        #1;
        n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL clr_pre irq got %b exp 1", bus.irq); end
        clr = 1'b1;
        #1;
        n_checks++; if (bus.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL clr_mid cnt_clr got %b exp 1", bus.cnt_clr); end
        n_checks++; if (bus.cnt_ld !== 1'b0) begin n_fail++; $display("FAIL clr_mid cnt_ld got %b exp 0", bus.cnt_ld); end
        n_checks++; if (bus.cnt_up !== 1'b0) begin n_fail++; $display("FAIL clr_mid cnt_up got %b exp 0", bus.cnt_up); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_mid busy got %b exp 0", bus.busy); end
        next_cycle();
        clr = 1'b0;
        #1;
        n_checks++; if (bus.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_after cnt_clr got %b exp 0", bus.cnt_clr); end
        n_checks++; if (bus.cnt_ld !== 1'b0) begin n_fail++; $display("FAIL clr_after cnt_ld got %b exp 0", bus.cnt_ld); end
        n_checks++; if (bus.cnt_up !== 1'b0) begin n_fail++; $display("FAIL clr_after cnt_up got %b exp 0", bus.cnt_up); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_after busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.expired !== 1'b0) begin n_fail++; $display("FAIL clr_after expired got %b exp 0", bus.expired); end
        n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL clr_after irq got %b exp 0", bus.irq); end
        n_checks++; if (bus.cnt_D !== 8'h00) begin n_fail++; $display("FAIL clr_after cnt_D got %h exp 00", bus.cnt_D); end
        n_checks++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL clr_after counter got %h exp 00", cnt); end
        $display("clr_mid_run: done, checks so far %0d", n_checks);
        // Start a period-3 run, then re-arm with period 5 while it is in RUN (before its expiry)
        bus.start = 1'b1; bus.period = 8'd3; bus.prescale = 8'd0; bus.mode = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        next_cycle();
        next_cycle();
        run_check(5, 0, 0, 12, "restart_in_run");
    endtask

    task automatic test_random;
        int p, s, m, len;
        for (int i = 0; i < 6; i++) begin
            p   = int'($urandom_range(1, 10));
            s   = int'($urandom_range(0, 3));
            m   = int'($urandom_range(0, 1));
            len = p * (s + 1);
            idle_ack();
            run_check(p, s, m, (m != 0) ? 3 * len + 4 : len + 6, "random");
        end
    endtask

    initial begin
        clr          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.mode     = 1'b0;
        bus.period   = '0;
        bus.prescale = '0;
        bus.irq_ack  = 1'b0;
        test_reset();
        test_oneshot_basic();
        test_autoreload();
        test_period_zero();
        test_stop_on_expiry();
        test_irq_ack();
        test_clr_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
